// File: rtl/aes_pkg.sv
// Shared definitions for the iterative AES-128 encryption controller.
// Contents: block/round constants, controller state encoding, and the
// byte-level helpers (S-box lookup, GF(2^8) doubling, round constant).
package aes_pkg;

    localparam int AES_BLK_W = 128;
    localparam int AES_NR    = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LAST = 2'd2,
        DONE = 2'd3
    } aes_fsm_e;

    // Forward S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry b sits at bit offset (255-b)*8, and 255-b == ~b for a byte.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [10:0] idx;
        idx = {~b, 3'b000};
        return SBOX[idx +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rcon(input logic [7:0] r);
        logic [7:0] v;
        case (r)
            8'd1:    v = 8'h01;
            8'd2:    v = 8'h02;
            8'd3:    v = 8'h04;
            8'd4:    v = 8'h08;
            8'd5:    v = 8'h10;
            8'd6:    v = 8'h20;
            8'd7:    v = 8'h40;
            8'd8:    v = 8'h80;
            8'd9:    v = 8'h1b;
            8'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/aes_round_dp.sv
// Combinational AES-128 round: SubBytes, ShiftRows, MixColumns (skipped on
// the final round), next round key via key expansion, AddRoundKey.
// Ports:
//   state_i  [127:0]  current state, byte 0 = [127:120], column-major
//   rkey_i   [127:0]  previous round key
//   round_i  [CNT_W]  round number, selects Rcon
//   last_i            final round: MixColumns bypassed
//   state_o  [127:0]  state after this round
//   rkey_o   [127:0]  round key used by this round
module aes_round_dp
    import aes_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic [AES_BLK_W-1:0] state_i,
    input  logic [AES_BLK_W-1:0] rkey_i,
    input  logic [CNT_W-1:0]     round_i,
    input  logic                 last_i,
    output logic [AES_BLK_W-1:0] state_o,
    output logic [AES_BLK_W-1:0] rkey_o
);

    logic [AES_BLK_W-1:0] sb_s;
    logic [AES_BLK_W-1:0] sr_s;
    logic [AES_BLK_W-1:0] mc_s;
    logic [31:0]          kt_s;
    logic [31:0]          w0_s, w1_s, w2_s, w3_s;

    // Key expansion: SubWord(RotWord(w3)) ^ Rcon, then the xor chain.
    assign kt_s = {sbox(rkey_i[23:16]), sbox(rkey_i[15:8]), sbox(rkey_i[7:0]), sbox(rkey_i[31:24])}
                ^ {rcon(8'(round_i)), 24'h000000};
    assign w0_s = rkey_i[127:96] ^ kt_s;
    assign w1_s = rkey_i[95:64]  ^ w0_s;
    assign w2_s = rkey_i[63:32]  ^ w1_s;
    assign w3_s = rkey_i[31:0]   ^ w2_s;
    assign rkey_o = {w0_s, w1_s, w2_s, w3_s};

    for (genvar i = 0; i < 16; i++) begin : g_sub
        assign sb_s[127-8*i -: 8] = sbox(state_i[127-8*i -: 8]);
    end

    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] a0_s, a1_s, a2_s, a3_s;
        // Row r of the state rotates left by r columns.
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign sr_s[127-8*(r+4*c) -: 8] = sb_s[127-8*(r+4*((c+r)%4)) -: 8];
        end
        assign a0_s = sr_s[127-32*c -: 8];
        assign a1_s = sr_s[119-32*c -: 8];
        assign a2_s = sr_s[111-32*c -: 8];
        assign a3_s = sr_s[103-32*c -: 8];
        assign mc_s[127-32*c -: 32] = {
            xtime(a0_s) ^ xtime(a1_s) ^ a1_s ^ a2_s ^ a3_s,
            a0_s ^ xtime(a1_s) ^ xtime(a2_s) ^ a2_s ^ a3_s,
            a0_s ^ a1_s ^ xtime(a2_s) ^ xtime(a3_s) ^ a3_s,
            xtime(a0_s) ^ a0_s ^ a1_s ^ a2_s ^ xtime(a3_s)
        };
    end

    assign state_o = (last_i ? sr_s : mc_s) ^ rkey_o;

endmodule

// File: rtl/aes_enc_round_ctrl.sv
// Iterative AES-128 encryption controller, one round per clock over the
// shared aes_round_dp datapath. Accepts plaintext/key in IDLE, runs rounds
// 1..9 in RUN and round 10 in LAST, holds the ciphertext in DONE until taken.
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   input handshake (in_ready decoded from fsm_q only)
//   plaintext, key        128-bit block and cipher key, byte 0 = [127:120]
//   out_valid / out_ready output handshake
//   ciphertext            always state_q
//   busy                  high in RUN and LAST
// Optional build macro AES_CTRL_BLKCNT_EN adds blk_cnt[31:0], a wrapping
// count of completed output handshakes.
module aes_enc_round_ctrl
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = AES_NR,
    parameter int CNT_W      = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [AES_BLK_W-1:0] plaintext,
    input  logic [AES_BLK_W-1:0] key,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [AES_BLK_W-1:0] ciphertext,
    output logic                 busy
`ifdef AES_CTRL_BLKCNT_EN
    ,
    output logic [31:0]          blk_cnt
`endif
);

    aes_fsm_e             fsm_q, fsm_d;
    logic [AES_BLK_W-1:0] state_q, state_d;
    logic [AES_BLK_W-1:0] rkey_q, rkey_d;
    logic [CNT_W-1:0]     rnd_q, rnd_d;
    logic [AES_BLK_W-1:0] dp_state_s;
    logic [AES_BLK_W-1:0] dp_rkey_s;

    aes_round_dp #(.CNT_W(CNT_W)) u_dp (
        .state_i (state_q),
        .rkey_i  (rkey_q),
        .round_i (rnd_q),
        .last_i  (fsm_q == LAST),
        .state_o (dp_state_s),
        .rkey_o  (dp_rkey_s)
    );

    assign ciphertext = state_q;

    // Next-state, round sequencing and handshake decode.
    always_comb begin
        fsm_d     = fsm_q;
        state_d   = state_q;
        rkey_d    = rkey_q;
        rnd_d     = rnd_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (fsm_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = plaintext ^ key;
                    rkey_d  = key;
                    rnd_d   = CNT_W'(1);
                    fsm_d   = RUN;
                end else begin
                    fsm_d = IDLE;
                end
            end
            RUN: begin
                busy    = 1'b1;
                state_d = dp_state_s;
                rkey_d  = dp_rkey_s;
                // Clamp so the counter can never run past the final round.
                if (rnd_q >= CNT_W'(NUM_ROUNDS - 1)) begin
                    rnd_d = CNT_W'(NUM_ROUNDS);
                    fsm_d = LAST;
                end else begin
                    rnd_d = rnd_q + CNT_W'(1);
                    fsm_d = RUN;
                end
            end
            LAST: begin
                busy    = 1'b1;
                state_d = dp_state_s;
                rkey_d  = dp_rkey_s;
                fsm_d   = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    rnd_d = {CNT_W{1'b0}};
                    fsm_d = IDLE;
                end else begin
                    fsm_d = DONE;
                end
            end
            default: begin
                state_d = {AES_BLK_W{1'b0}};
                rkey_d  = {AES_BLK_W{1'b0}};
                rnd_d   = {CNT_W{1'b0}};
                fsm_d   = IDLE;
            end
        endcase
    end

    // Controller state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= IDLE;
            state_q <= {AES_BLK_W{1'b0}};
            rkey_q  <= {AES_BLK_W{1'b0}};
            rnd_q   <= {CNT_W{1'b0}};
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            rkey_q  <= rkey_d;
            rnd_q   <= rnd_d;
        end
    end

`ifdef AES_CTRL_BLKCNT_EN
    logic [31:0] blk_cnt_q;

    // Completed-block counter, wraps naturally at 2**32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_cnt_q <= 32'd0;
        end else if (out_valid && out_ready) begin
            blk_cnt_q <= blk_cnt_q + 32'd1;
        end else begin
            blk_cnt_q <= blk_cnt_q;
        end
    end

    assign blk_cnt = blk_cnt_q;
`endif

endmodule

// File: tb/tb_aes_enc_round_ctrl.sv
// Bench for aes_enc_round_ctrl: FIPS-197 known answers, backpressure,
// back-to-back throughput, mid-flight reset, randomized blocks against a
// behavioural AES-128 model (S-box derived from GF(2^8) inversion).
module tb_aes_enc_round_ctrl;

    localparam logic [127:0] PT_B = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] K_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_C = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K_C  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] plaintext;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] ciphertext;
    logic         busy;
`ifdef AES_CTRL_BLKCNT_EN
    logic [31:0]  blk_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;
    int hs_count = 0;
    logic [7:0] sb_tab [256];

    always #5 clk = ~clk;

    aes_enc_round_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .plaintext  (plaintext),
        .key        (key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ciphertext (ciphertext),
        .busy       (busy)
`ifdef AES_CTRL_BLKCNT_EN
        ,
        .blk_cnt    (blk_cnt)
`endif
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, t, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv;
            t = inv;
            for (int k = 0; k < 4; k++) begin
                t = {t[6:0], t[7]};
                s = s ^ t;
            end
            sb_tab[x] = s ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] k);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a [4];
        logic [7:0]   rc;
        logic [31:0]  tmp;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sb_tab[tmp[31:24]], sb_tab[tmp[23:16]], sb_tab[tmp[15:8]], sb_tab[tmp[7:0]]}
                    ^ {rc, 24'h000000};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ k[127-8*i -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) t[i] = sb_tab[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) s[r+4*c] = t[r+4*((c+r)%4)];
            if (rnd != 10) begin
                for (int c = 0; c < 4; c++) begin
                    for (int r = 0; r < 4; r++) a[r] = s[4*c+r];
                    for (int r = 0; r < 4; r++)
                        s[4*c+r] = gmul(8'h02, a[r]) ^ gmul(8'h03, a[(r+1)%4]) ^ a[(r+2)%4] ^ a[(r+3)%4];
                end
            end
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) s[4*c+r] = s[4*c+r] ^ w[4*rnd+c][31-8*r -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // ---------------- stimulus helpers ----------------
    function automatic logic [127:0] junk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        check("in_ready_wait", 128'(in_ready), 128'd1);
    endtask

    task automatic start_block(input logic [127:0] pt, input logic [127:0] k);
        wait_ready();
        in_valid  = 1'b1;
        plaintext = pt;
        key       = k;
        tick();
        in_valid  = 1'b0;
        plaintext = junk();   // inputs are only sampled on the accept edge
        key       = junk();
    endtask

    // Latency counts the accept edge: 1 IDLE + 9 RUN + 1 LAST = 11 edges.
    task automatic finish_block(input string tag, input logic [127:0] exp, input int bp, input bit pulse);
        int lat = 1;
        check({tag, "_busy"}, 128'(busy), 128'd1);
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 128'(lat), 128'd11);
        check({tag, "_ct"}, ciphertext, exp);
        for (int i = 0; i < bp; i++) begin
            in_valid = pulse ? 1'($urandom_range(0, 1)) : 1'b0;
            plaintext = junk();
            key       = junk();
            tick();
            check({tag, "_hold_ct"}, ciphertext, exp);
            check({tag, "_hold_valid"}, 128'(out_valid), 128'd1);
            check({tag, "_hold_ready"}, 128'(in_ready), 128'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        check({tag, "_no_same_cycle_accept"}, 128'(in_ready), 128'd0);
        tick();
        out_ready = 1'b0;
        hs_count++;
        check({tag, "_post_valid"}, 128'(out_valid), 128'd0);
        check({tag, "_post_ready"}, 128'(in_ready), 128'd1);
        check({tag, "_post_ct_kept"}, ciphertext, exp);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [127:0] pt, k, hs_ct [2];
        int hs_cyc [2];
        int got, acc, cyc;
        bit acc_now;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        plaintext = 128'd0; key = 128'd0;
        build_sbox();
        #12;
        check("rst_in_ready", 128'(in_ready), 128'd1);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_ct", ciphertext, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // FIPS-197 App.B with 20 cycles of backpressure and ignored in_valid pulses
        start_block(PT_B, K_B);
        finish_block("fips_b", CT_B, 20, 1'b1);
        // FIPS-197 App.C.1
        start_block(PT_C, K_C);
        finish_block("fips_c1", CT_C, 2, 1'b0);

        // Back-to-back with in_valid held high and out_ready high
        wait_ready();
        out_ready = 1'b1; in_valid = 1'b1; plaintext = PT_B; key = K_B;
        got = 0; acc = 0; cyc = 0;
        hs_ct[0] = 128'd0; hs_ct[1] = 128'd0; hs_cyc[0] = 0; hs_cyc[1] = 0;
        while (got < 2 && cyc < 60) begin
            if (out_valid && out_ready) begin
                hs_ct[got]  = ciphertext;
                hs_cyc[got] = cyc;
                got++;
            end
            acc_now = in_ready && in_valid;
            tick();
            cyc++;
            if (acc_now) begin
                acc++;
                if (acc == 1) begin
                    plaintext = PT_C; key = K_C;
                end else begin
                    in_valid = 1'b0; plaintext = junk(); key = junk();
                end
            end
        end
        out_ready = 1'b0;
        hs_count += got;
        check("b2b_count", 128'(got), 128'd2);
        check("b2b_ct0", hs_ct[0], CT_B);
        check("b2b_ct1", hs_ct[1], CT_C);
        check("b2b_spacing", 128'(hs_cyc[1] - hs_cyc[0]), 128'd12);

        // Asynchronous reset at round 5 discards the block
        start_block(PT_B, K_B);
        repeat (4) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", 128'(in_ready), 128'd1);
        check("midrst_out_valid", 128'(out_valid), 128'd0);
        check("midrst_busy", 128'(busy), 128'd0);
        check("midrst_ct", ciphertext, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        hs_count = 0;
        tick();
        check("midrst_idle_valid", 128'(out_valid), 128'd0);
        start_block(PT_C, K_C);
        finish_block("after_rst", CT_C, 1, 1'b0);

        // Randomized blocks against the reference model
        for (int n = 0; n < 8; n++) begin
            pt = junk();
            k  = junk();
            repeat ($urandom_range(0, 3)) tick();
            start_block(pt, k);
            finish_block("rand", aes_ref(pt, k), int'($urandom_range(0, 3)), 1'b1);
        end

`ifdef AES_CTRL_BLKCNT_EN
        check("blk_cnt", 128'(blk_cnt), 128'(hs_count));
        start_block(PT_B, K_B);
        repeat (10) tick();
        force dut.blk_cnt_q = 32'hFFFFFFFF;
        #1;
        release dut.blk_cnt_q;
        finish_block("wrap", CT_B, 0, 1'b0);
        check("blk_cnt_wrap", 128'(blk_cnt), 128'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1);
    end

endmodule
